// File: rtl/rx_control.sv
// rx_control -- UART receiver, serial to parallel.
//
// Oversamples the serial line on the shared baud tick (SAMPLING ticks per
// bit). It validates the start bit at mid-bit and shifts DATA_WIDTH data bits
// in LSB-first. It then checks an optional parity bit and one or two stop
// bits. Every completed frame is delivered with a one-cycle data_valid pulse,
// even when it carries an error flag.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   bclk          in   oversampling tick enable (one clk wide)
//   parity        in   00 none, 01 odd, 10 even, 11 none (latched per frame)
//   stop          in   0x one stop bit, 1x two stop bits (latched per frame)
//   s_data_in     in   asynchronous serial line, idle high
//   p_data_out    out  last received word
//   data_valid    out  one-cycle pulse when p_data_out and the flags update
//   parity_error  out  parity mismatch on the last word
//   framing_error out  a stop bit was sampled low on the last word
//   busy          out  high from start-bit validation until frame end
module rx_control #(
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLING   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic [1:0]            parity,
  input  logic [1:0]            stop,
  input  logic                  s_data_in,
  output logic [DATA_WIDTH-1:0] p_data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(SAMPLING);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLING - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    armed_q, armed_d;
  logic                    par_en_q, par_en_d;
  logic                    par_odd_q, par_odd_d;
  logic                    stop2_q, stop2_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    dv_q, dv_d;
  logic                    pe_q, pe_d;
  logic                    fe_q, fe_d;

  logic                    mid_tick;
  logic                    bit_tick;
  logic                    last_stop;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= s_data_in;
      rx_q      <= rx_meta_q;
    end
  end

  // In START the counter runs from the start-detect tick, so half a bit lands
  // on CNT_MID. Every later state is entered exactly at a mid-bit tick, so a
  // full bit period later (CNT_LAST) is again mid-bit.
  assign mid_tick  = bclk && (cnt_q == CNT_MID);
  assign bit_tick  = bclk && (cnt_q == CNT_LAST);
  assign last_stop = (bit_cnt_q == BIT_W'(stop2_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    pe_d      = pe_q;
    fe_d      = fe_q;

    if (bclk) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (bclk) begin
          if (rx_q) begin
            // A high line re-arms; a line held low (break) never does.
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d   = S_START;
            cnt_d     = '0;
            bit_cnt_d = '0;
            par_en_d  = (parity == 2'b01) || (parity == 2'b10);
            par_odd_d = (parity == 2'b01);
            stop2_d   = (stop >= 2'b10);
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end

      S_START: begin
        if (mid_tick) begin
          cnt_d   = '0;
          state_d = rx_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          shift_d = {rx_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            cnt_d     = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          // Even parity expects the XOR of the data; odd expects its inverse.
          perr_d  = rx_q != (^shift_q ^ par_odd_q);
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          if (!rx_q) begin
            ferr_d = 1'b1;
          end
          if (last_stop) begin
            dout_d    = shift_q;
            dv_d      = 1'b1;
            pe_d      = perr_q;
            fe_d      = ferr_q | ~rx_q;
            bit_cnt_d = '0;
            cnt_d     = '0;
            // Re-arm only once the line is seen high again. Mid-stop-bit on
            // a good frame this happens on the very next tick.
            armed_d   = 1'b0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      armed_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      armed_q   <= armed_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
    end
  end

  // The shift register is pure datapath: it is fully rewritten every frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign p_data_out    = dout_q;
  assign data_valid    = dv_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;
  assign busy          = (state_q == S_DATA) || (state_q == S_PARITY) ||
                         (state_q == S_STOP);

endmodule

// File: tb/tb_rx_control.sv
module tb_rx_control;

  localparam int DW   = 8;
  localparam int SAMP = 16;
  localparam int DIV  = 4;   // clk cycles per bclk tick

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bclk = 1'b0;
  logic [1:0]    parity = 2'b00;
  logic [1:0]    stop = 2'b00;
  logic          s_data_in = 1'b1;
  logic [DW-1:0] p_data_out;
  logic          data_valid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;

  rx_control #(.DATA_WIDTH(DW), .SAMPLING(SAMP)) dut (
    .clk          (clk),
    .reset        (reset),
    .bclk         (bclk),
    .parity       (parity),
    .stop         (stop),
    .s_data_in    (s_data_in),
    .p_data_out   (p_data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int div_cnt = 0;
  always @(negedge clk) begin
    if (div_cnt == DIV - 1) begin
      div_cnt <= 0;
      bclk    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      bclk    <= 1'b0;
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    bit            pe;
    bit            fe;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Returns #1 after the n-th rising edge that carries a bclk tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!bclk);
    end
    #1;
  endtask

  task automatic send_bit(input bit b);
    s_data_in = b;
    wait_ticks(SAMP);
  endtask

  // Parity bit that makes the total count of ones even.
  function automatic bit even_bit(input logic [DW-1:0] d);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return bit'(ones % 2);
  endfunction

  task automatic send_frame(input logic [DW-1:0] w, input logic [1:0] pm,
                            input logic [1:0] sm, input bit pflip,
                            input bit [1:0] stop_low, input bit chg_par,
                            input logic [1:0] new_par);
    bit   pen;
    bit   two;
    bit   pbit;
    exp_t e;
    pen  = (pm == 2'b01) || (pm == 2'b10);
    two  = (sm >= 2'b10);
    pbit = (pm == 2'b10) ? even_bit(w) : ~even_bit(w);
    if (pflip) pbit = ~pbit;
    e.data = w;
    e.pe   = pen && pflip;
    e.fe   = stop_low[0] || (two && stop_low[1]);
    expq.push_back(e);
    parity = pm;
    stop   = sm;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) begin
      send_bit(w[i]);
      if (chg_par && i == 2) parity = new_par;
    end
    if (pen) send_bit(pbit);
    send_bit(!stop_low[0]);
    if (two) send_bit(!stop_low[1]);
    s_data_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, int'(p_data_out), 0);
    check({tag, "_valid"}, int'(data_valid), 0);
    check({tag, "_perr"}, int'(parity_error), 0);
    check({tag, "_ferr"}, int'(framing_error), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    exp_t e;

    // Monitor: pops one expectation per data_valid cycle.
    fork
      forever begin
        @(negedge clk);
        if (data_valid) begin
          if (expq.size() == 0) begin
            check("spurious_valid", int'(data_valid), 0);
          end else begin
            e = expq.pop_front();
            check("word", int'(p_data_out), int'(e.data));
            check("parity_error", int'(parity_error), int'(e.pe));
            check("framing_error", int'(framing_error), int'(e.fe));
          end
        end
      end
      forever begin
        @(negedge clk);
        if (busy) busy_cycles++;
      end
    join_none

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    wait_ticks(4);

    // 0xA5, no parity, one stop; busy spans validated start to mid-stop.
    b0 = busy_cycles;
    send_frame(8'hA5, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    check("busy_len", busy_cycles - b0, (DW + 0 + 1) * SAMP * DIV);

    // Even parity, correct then wrong parity bit.
    send_frame(8'h3C, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    send_frame(8'h3C, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00);

    // Odd parity; second time the parity input changes mid-frame.
    send_frame(8'h07, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    send_frame(8'h07, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00);
    parity = 2'b00;

    // Two stop bits, second one low, then the line is held low.
    send_frame(8'h81, 2'b00, 2'b10, 1'b0, 2'b10, 1'b0, 2'b00);
    s_data_in = 1'b0;
    b0 = busy_cycles;
    wait_ticks(3 * SAMP);
    check("break_busy", busy_cycles - b0, 0);
    s_data_in = 1'b1;
    wait_ticks(SAMP);
    send_frame(8'hC3, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);

    // Short low glitch on an idle line.
    wait_ticks(SAMP);
    b0 = busy_cycles;
    s_data_in = 1'b0;
    wait_ticks(4);
    s_data_in = 1'b1;
    wait_ticks(3 * SAMP);
    check("glitch_busy", busy_cycles - b0, 0);

    // Back-to-back frames, then a third frame cut short by reset.
    send_frame(8'h55, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    send_frame(8'hAA, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("busy_mid_frame", int'(busy), 1);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    s_data_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ticks(2 * SAMP);

    // Randomized frames against the reference model.
    for (int n = 0; n < 12; n++) begin
      logic [DW-1:0] w;
      logic [1:0]    pm;
      logic [1:0]    sm;
      bit            pf;
      bit [1:0]      sl;
      w  = DW'($urandom_range(0, (1 << DW) - 1));
      pm = 2'($urandom_range(0, 3));
      sm = 2'($urandom_range(0, 3));
      pf = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(w, pm, sm, pf, sl, 1'b0, 2'b00);
      wait_ticks(SAMP);
    end

    wait_ticks(2 * SAMP);
    check("pending_expect", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
